// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory-access initiator between the execute stage and a word-addressed
//   data memory. It takes one RV32I load or store per valid/ready handshake.
//   Sub-word stores are done as read-modify-write. Illegal, misaligned and
//   out-of-range requests are rejected without issuing any memory strobe.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   req_valid / req_ready        request handshake
//   req_is_store, req_funct3     operation (funct3 gives the RV32I width/sign)
//   req_addr, req_wdata          byte address and store data
//   resp_valid                   one-cycle completion pulse
//   resp_rdata, resp_err         extended load data and reject flag
//   MemRead, MemWrite            memory strobes (mutually exclusive)
//   read_address                 word-aligned address of the access
//   Write_data                   full word to write
//   MemData_out                  combinational memory read data
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] read_address,
    output logic [31:0] Write_data,
    input  logic [31:0] MemData_out
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ST_WORD, S_RMW_RD, S_RMW_WR, S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_out_of_range;
    logic        w_err;
    logic [31:0] w_lane;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    // Request validation, evaluated on the live request inputs in IDLE.
    assign w_illegal      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                          || (req_is_store && req_funct3[2]);
    assign w_misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                          || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_out_of_range = (req_addr >= ADDR_LIMIT);
    assign w_err          = w_illegal || w_misalign || w_out_of_range;

    // Bring the addressed byte/halfword down to bit 0, then extend it.
    assign w_lane = MemData_out >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_ext = w_lane;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_ext = {24'h0, w_lane[7:0]};
            3'b101:  w_load_ext = {16'h0, w_lane[15:0]};
            default: w_load_ext = w_lane;
        endcase
    end

    // Read-modify-write merge: each byte lane takes store data when it is
    // covered by the SB byte or the SH halfword, otherwise keeps the old word.
    // For SH the upper lane of the halfword takes wdata[15:8].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic w_hit;
            assign w_hit = r_funct3[0] ? (r_addr[1] == LANE[1])
                                       : (r_addr[1:0] == LANE);
            assign w_merged[8*gi +: 8] = !w_hit ? r_merge[8*gi +: 8]
                                       : ((r_funct3[0] && LANE[0]) ? r_wdata[15:8]
                                                                   : r_wdata[7:0]);
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_merge  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_err    <= w_err;
                        r_rdata  <= 32'h0;
                    end
                end
                S_LOAD:   r_rdata <= w_load_ext;
                S_RMW_RD: r_merge <= MemData_out;
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err)
                        w_state_next = S_RESP;
                    else if (!req_is_store)
                        w_state_next = S_LOAD;
                    else if (req_funct3[1])
                        w_state_next = S_ST_WORD;
                    else
                        w_state_next = S_RMW_RD;
                end
            end
            S_LOAD, S_ST_WORD, S_RMW_WR: w_state_next = S_RESP;
            S_RMW_RD:                    w_state_next = S_RMW_WR;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        req_ready    = (r_state == S_IDLE) && !reset;
        resp_valid   = (r_state == S_RESP);
        resp_rdata   = (r_state == S_RESP) ? r_rdata : 32'h0;
        resp_err     = (r_state == S_RESP) && r_err;
        MemRead      = (r_state == S_LOAD) || (r_state == S_RMW_RD);
        MemWrite     = (r_state == S_ST_WORD) || (r_state == S_RMW_WR);
        read_address = (r_state == S_IDLE) ? 32'h0 : {r_addr[31:2], 2'b00};
        Write_data   = 32'h0;
        if (r_state == S_ST_WORD)
            Write_data = r_wdata;
        else if (r_state == S_RMW_WR)
            Write_data = w_merged;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] read_address;
    logic [31:0] Write_data;
    logic [31:0] MemData_out;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .read_address(read_address), .Write_data(Write_data),
        .MemData_out(MemData_out)
    );

    // Data memory model: word k initialised to k, combinational read.
    logic [31:0] mem [64];
    logic        mem_load;
    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'(k);
        end else if (MemWrite) begin
            mem[read_address[7:2]] <= Write_data;
        end
    end
    assign MemData_out = mem[read_address[7:2]];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wd;
    } op_t;

    resp_t       exp_q[$];
    resp_t       resp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    int          resp_cyc = 0;
    logic [31:0] last_wd = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: strobe counters and response capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (MemRead) rd_cnt <= rd_cnt + 1;
        if (MemWrite) begin
            wr_cnt  <= wr_cnt + 1;
            last_wd <= Write_data;
        end
        if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
        if (resp_valid) begin
            resp_q.push_back({resp_rdata, resp_err});
            resp_cyc <= cyc;
        end
    end

    // Driver: one handshake, then wait (bounded) for the response.
    task automatic do_access(input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output int rd_d, output int wr_d,
                             output logic to);
        int acc, rd0, wr0, n0;
        to = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        acc = cyc; rd0 = rd_cnt; wr0 = wr_cnt; n0 = resp_q.size();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (resp_q.size() > n0) begin
                to = 1'b0;
                break;
            end
        end
        lat  = resp_cyc - acc + 1;
        rd_d = rd_cnt - rd0;
        wr_d = wr_cnt - wr0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_load = 1'b1; req_valid = 1'b0;
        req_is_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, MemRead, MemWrite, resp_err} !== 5'b0 ||
            read_address !== 32'h0 || Write_data !== 32'h0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rv=%b rd=%b wr=%b ra=%h wd=%h, want all 0",
                     req_ready, resp_valid, MemRead, MemWrite, read_address, Write_data);
        end
        reset = 1'b0; mem_load = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        $display("reset: ready=%b after deassert", req_ready);
    endtask

    task automatic test_load_word();
        int lat, rd, wr; logic to; resp_t ob, ex;
        exp_q.push_back({32'h00000003, 1'b0});
        do_access(1'b0, 3'b010, 32'h0C, 32'h0, lat, rd, wr, to);
        ex = exp_q.pop_front();
        checks++;
        if (to) begin
            errors++; $display("FAIL lw_timeout: no response want rdata=%h", ex.rdata);
        end else begin
            ob = resp_q.pop_front();
            if (ob !== ex || lat !== 2 || rd !== 1 || wr !== 0) begin
                errors++;
                $display("FAIL lw_0c: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want %h 0 2 1 0",
                         ob.rdata, ob.err, lat, rd, wr, ex.rdata);
            end
            $display("LW 0x0C -> %h err=%b lat=%0d", ob.rdata, ob.err, lat);
        end
    endtask

    task automatic test_sub_word_store();
        int lat, rd, wr; logic to; resp_t ob, ex;
        op_t ops [7] = '{
            '{1'b1, 3'b000, 32'h0D, 32'h123456AB, 32'h0,        3, 1, 1, 32'h0000AB03},
            '{1'b0, 3'b000, 32'h0D, 32'h0,        32'hFFFFFFAB, 2, 1, 0, 32'h0},
            '{1'b0, 3'b100, 32'h0D, 32'h0,        32'h000000AB, 2, 1, 0, 32'h0},
            '{1'b1, 3'b001, 32'h0E, 32'h00008001, 32'h0,        3, 1, 1, 32'h8001AB03},
            '{1'b0, 3'b001, 32'h0E, 32'h0,        32'hFFFF8001, 2, 1, 0, 32'h0},
            '{1'b0, 3'b101, 32'h0E, 32'h0,        32'h00008001, 2, 1, 0, 32'h0},
            '{1'b0, 3'b010, 32'h0C, 32'h0,        32'h8001AB03, 2, 1, 0, 32'h0}
        };
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({ops[i].rdata, 1'b0});
            do_access(ops[i].st, ops[i].f3, ops[i].addr, ops[i].wdata, lat, rd, wr, to);
            ex = exp_q.pop_front();
            checks++;
            if (to) begin
                errors++; $display("FAIL subword_timeout op%0d: no response", i);
                continue;
            end
            ob = resp_q.pop_front();
            if (ob !== ex || lat !== ops[i].lat || rd !== ops[i].rd || wr !== ops[i].wr ||
                (ops[i].st && last_wd !== ops[i].wd)) begin
                errors++;
                $display("FAIL subword_op%0d: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d wd=%h want %h 0 %0d %0d %0d %h",
                         i, ob.rdata, ob.err, lat, rd, wr, last_wd,
                         ex.rdata, ops[i].lat, ops[i].rd, ops[i].wr, ops[i].wd);
            end
            $display("subword op%0d st=%b f3=%b addr=%h -> rdata=%h lat=%0d wd=%h",
                     i, ops[i].st, ops[i].f3, ops[i].addr, ob.rdata, lat, last_wd);
        end
    endtask

    task automatic test_store_word();
        int lat, rd, wr; logic to; resp_t ob, ex;
        op_t ops [2] = '{
            '{1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0,        2, 0, 1, 32'hDEADBEEF},
            '{1'b0, 3'b010, 32'h20, 32'h0,        32'hDEADBEEF, 2, 1, 0, 32'h0}
        };
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({ops[i].rdata, 1'b0});
            do_access(ops[i].st, ops[i].f3, ops[i].addr, ops[i].wdata, lat, rd, wr, to);
            ex = exp_q.pop_front();
            checks++;
            if (to) begin
                errors++; $display("FAIL sw_timeout op%0d: no response", i);
                continue;
            end
            ob = resp_q.pop_front();
            if (ob !== ex || lat !== ops[i].lat || rd !== ops[i].rd || wr !== ops[i].wr ||
                (ops[i].st && last_wd !== ops[i].wd)) begin
                errors++;
                $display("FAIL sw_op%0d: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d wd=%h want %h 0 %0d %0d %0d %h",
                         i, ob.rdata, ob.err, lat, rd, wr, last_wd,
                         ex.rdata, ops[i].lat, ops[i].rd, ops[i].wr, ops[i].wd);
            end
            $display("word op%0d st=%b addr=%h -> rdata=%h lat=%0d", i, ops[i].st, ops[i].addr, ob.rdata, lat);
        end
    endtask

    task automatic test_errors();
        int lat, rd, wr; logic to; resp_t ob, ex;
        op_t ops [4] = '{
            '{1'b0, 3'b010, 32'h0D,  32'h0,        32'h0, 1, 0, 0, 32'h0},
            '{1'b1, 3'b001, 32'h0F,  32'hFFFFFFFF, 32'h0, 1, 0, 0, 32'h0},
            '{1'b0, 3'b010, 32'h100, 32'h0,        32'h0, 1, 0, 0, 32'h0},
            '{1'b0, 3'b011, 32'h00,  32'h0,        32'h0, 1, 0, 0, 32'h0}
        };
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({32'h0, 1'b1});
            do_access(ops[i].st, ops[i].f3, ops[i].addr, ops[i].wdata, lat, rd, wr, to);
            ex = exp_q.pop_front();
            checks++;
            if (to) begin
                errors++; $display("FAIL err_timeout op%0d: no response", i);
                continue;
            end
            ob = resp_q.pop_front();
            if (ob !== ex || lat !== 1 || rd !== 0 || wr !== 0) begin
                errors++;
                $display("FAIL err_op%0d: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want 0 1 1 0 0",
                         i, ob.rdata, ob.err, lat, rd, wr);
            end
            $display("error op%0d st=%b f3=%b addr=%h -> err=%b lat=%0d", i, ops[i].st, ops[i].f3, ops[i].addr, ob.err, lat);
        end
    endtask

    task automatic test_reset_midop();
        int wr0, n0, lat, rd, wr; logic to; resp_t ob, ex;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'h000000EE;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0; wr0 = wr_cnt; n0 = resp_q.size();
        @(negedge clk);
        checks++;
        if (MemRead !== 1'b1) begin
            errors++; $display("FAIL rmw_rd_state: MemRead=%b want 1", MemRead);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || MemWrite !== 1'b0) begin
            errors++; $display("FAIL reset_hold: ready=%b wr=%b want 0 0", req_ready, MemWrite);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wr_cnt !== wr0 || resp_q.size() !== n0 || mem[4] !== 32'h4) begin
            errors++;
            $display("FAIL reset_abort: writes=%0d resps=%0d mem4=%h want 0 0 00000004",
                     wr_cnt - wr0, resp_q.size() - n0, mem[4]);
        end
        $display("reset mid-RMW: writes=%0d mem4=%h", wr_cnt - wr0, mem[4]);
        exp_q.push_back({32'h00000005, 1'b0});
        do_access(1'b0, 3'b010, 32'h14, 32'h0, lat, rd, wr, to);
        ex = exp_q.pop_front();
        checks++;
        if (to) begin
            errors++; $display("FAIL post_reset_timeout: no response");
        end else begin
            ob = resp_q.pop_front();
            if (ob !== ex || lat !== 2) begin
                errors++;
                $display("FAIL post_reset_lw: got rdata=%h err=%b lat=%0d want 00000005 0 2", ob.rdata, ob.err, lat);
            end
            $display("LW 0x14 after reset -> %h", ob.rdata);
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2; resp_t ob, ex;
        a1 = 0; a2 = 0;
        exp_q.push_back({32'h0, 1'b0});
        exp_q.push_back({32'h1, 1'b0});
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        a1 = cyc; req_addr = 32'h4;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        a2 = cyc; req_valid = 1'b0;
        for (int i = 0; i < 20 && resp_q.size() < 2; i++) @(posedge clk);
        #1;
        checks++;
        if (a2 - a1 !== 3) begin
            errors++; $display("FAIL b2b_spacing: got %0d cycles want 3", a2 - a1);
        end
        for (int i = 0; i < 2; i++) begin
            ex = exp_q.pop_front();
            checks++;
            if (resp_q.size() == 0) begin
                errors++; $display("FAIL b2b_resp%0d: no response want rdata=%h", i, ex.rdata);
                continue;
            end
            ob = resp_q.pop_front();
            if (ob !== ex) begin
                errors++;
                $display("FAIL b2b_resp%0d: got rdata=%h err=%b want %h 0", i, ob.rdata, ob.err, ex.rdata);
            end
            $display("back-to-back resp%0d -> %h", i, ob.rdata);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_sub_word_store();
        test_store_word();
        test_errors();
        test_reset_midop();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL strobe_exclusive: both high %0d cycles want 0", both_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
